// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch controller: state encoding, button indices, defaults.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LAP  = 2'b10
  } state_t;

  localparam int unsigned BTN_CLR   = 0;
  localparam int unsigned BTN_START = 1;
  localparam int unsigned BTN_STOP  = 2;
  localparam int unsigned BTN_LAP   = 3;

  localparam int unsigned TICK_DIV_DEF = 100000;
  localparam int unsigned DEBOUNCE_DEF = 1000000;

  // RUN and LAP both keep the prescaler running.
  function automatic logic is_active(state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// One button input path: 2-flop synchronizer, debounce counter, registered rising-edge press.
module btn_debounce #(
  parameter int unsigned DEBOUNCE = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Flip the debounced level after DEBOUNCE consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 != level) begin
      if (cnt == CW'(DEBOUNCE - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // Single-cycle press on the debounced rising edge; releases are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: button conditioning, IDLE/RUN/LAP FSM, count-tick prescaler.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       lap_load,
  output logic       disp_lap,
  output logic [1:0] state_o
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] presc;
  logic [3:0]    press;
  logic [3:0]    level_unused;
  logic          tick;
  logic          p_clr;
  logic          p_start;
  logic          p_stop;
  logic          p_lap;
  logic          cnt_en_c;
  logic          cnt_clr_c;
  logic          lap_load_c;
  logic          disp_lap_c;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn[i]),
      .level (level_unused[i]),
      .press (press[i])
    );
  end

  assign p_clr   = press[BTN_CLR];
  assign p_start = press[BTN_START];
  assign p_stop  = press[BTN_STOP];
  assign p_lap   = press[BTN_LAP];
  assign tick    = is_active(state) && (presc == PW'(TICK_DIV - 1));
  assign state_o = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state; clear > stop > start > lap, lower presses are dropped.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (!p_clr && !p_stop && p_start) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (p_clr || p_stop)      state_next = ST_IDLE;
        else if (!p_start && p_lap) state_next = ST_LAP;
      end
      ST_LAP: begin
        if (p_clr || p_stop)      state_next = ST_IDLE;
        else if (!p_start && p_lap) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode; pulses are registered below so they land one cycle after the cause.
  always_comb begin
    cnt_en_c   = 1'b0;
    cnt_clr_c  = 1'b0;
    lap_load_c = 1'b0;
    disp_lap_c = (state_next == ST_LAP);
    case (state)
      ST_IDLE: begin
        cnt_clr_c = p_clr;
        cnt_en_c  = !p_clr && !p_stop && !p_start && p_lap;
      end
      ST_RUN, ST_LAP: begin
        cnt_clr_c  = p_clr;
        cnt_en_c   = tick && !p_clr && !p_stop;
        lap_load_c = (state == ST_RUN) && !p_clr && !p_stop && !p_start && p_lap;
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_en   <= 1'b0;
      cnt_clr  <= 1'b0;
      lap_load <= 1'b0;
      disp_lap <= 1'b0;
    end else begin
      cnt_en   <= cnt_en_c;
      cnt_clr  <= cnt_clr_c;
      lap_load <= lap_load_c;
      disp_lap <= disp_lap_c;
    end
  end

  // Prescaler: free-runs through RUN/LAP, parked at 0 otherwise so RUN entry is phase-aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (is_active(state) && is_active(state_next)) begin
      presc <= tick ? '0 : presc + PW'(1);
    end else begin
      presc <= '0;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_DIV=10, DEBOUNCE=4.
module tb_stopwatch_ctrl;

  localparam int TD = 10;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       cnt_en;
  logic       cnt_clr;
  logic       lap_load;
  logic       disp_lap;
  logic [1:0] state_o;

  stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .lap_load (lap_load),
    .disp_lap (disp_lap),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: edge-indexed histories of raw and debounced button values.
  int         k = 0;
  logic [3:0] rawh[$];
  logic [3:0] lvlh[$];
  int         last_tog[4];
  logic [3:0] m_press = '0;
  logic [1:0] m_st    = 2'b00;
  int         m_entry = 0;
  logic       m_en    = 1'b0;
  logic       m_clr   = 1'b0;
  logic       m_ll    = 1'b0;
  logic       m_disp  = 1'b0;

  int cyc      = 0;
  int en_cnt   = 0;
  int clr_cnt  = 0;
  int ll_cnt   = 0;
  int first_en = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at step %0d", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic logic synced(int j, int i);
    logic [3:0] v;
    if (j < 2) return 1'b0;
    v = rawh[j-2];
    return v[i];
  endfunction

  // Advance the model by one rising edge given the inputs sampled at that edge.
  task automatic model_edge(input logic [3:0] b, input logic r);
    logic [3:0] cur, prev, lv_new;
    logic       tick, p_clr, p_start, p_stop, p_lap, tog;
    logic [1:0] ns;
    rawh.push_back(b);
    if (r) begin
      rawh[k] = '0;
      if (k >= 1) rawh[k-1] = '0;
      for (int i = 0; i < 4; i++) last_tog[i] = k;
      lvlh.push_back(4'b0000);
      m_press = '0;
      m_st = 2'b00; m_en = 0; m_clr = 0; m_ll = 0; m_disp = 0;
    end else begin
      p_clr = m_press[0]; p_start = m_press[1]; p_stop = m_press[2]; p_lap = m_press[3];
      tick = (m_st == 2'b01 || m_st == 2'b10) && (((k - m_entry) % TD) == 0);
      ns = m_st; m_en = 0; m_clr = 0; m_ll = 0;
      if (p_clr) begin
        ns = 2'b00; m_clr = 1;
      end else if (p_stop) begin
        ns = 2'b00;
      end else if (m_st == 2'b00) begin
        if (p_start) begin ns = 2'b01; m_entry = k; end
        else if (p_lap) m_en = 1;
      end else if (m_st == 2'b01 || m_st == 2'b10) begin
        m_en = tick;
        if (!p_start && p_lap) begin
          if (m_st == 2'b01) begin ns = 2'b10; m_ll = 1; end
          else ns = 2'b01;
        end
      end else begin
        ns = 2'b00;
      end
      m_st = ns;
      m_disp = (ns == 2'b10);
      cur  = lvlh[k-1];
      prev = (k >= 2) ? lvlh[k-2] : 4'b0000;
      for (int i = 0; i < 4; i++) begin
        tog = (k - last_tog[i]) >= DB;
        for (int j = k - DB + 1; j <= k; j++) if (synced(j, i) == cur[i]) tog = 0;
        lv_new[i] = cur[i] ^ tog;
        if (tog) last_tog[i] = k;
      end
      lvlh.push_back(lv_new);
      m_press = cur & ~prev;
    end
    k++;
  endtask

  task automatic check_outputs();
    chk("state_o",  32'(state_o),  32'(m_st));
    chk("cnt_en",   32'(cnt_en),   32'(m_en));
    chk("cnt_clr",  32'(cnt_clr),  32'(m_clr));
    chk("lap_load", 32'(lap_load), 32'(m_ll));
    chk("disp_lap", 32'(disp_lap), 32'(m_disp));
    if (cnt_en === 1'b1) begin
      en_cnt++;
      if (first_en < 0) first_en = cyc;
    end
    if (cnt_clr === 1'b1) clr_cnt++;
    if (lap_load === 1'b1) ll_cnt++;
  endtask

  task automatic step(input logic [3:0] b, input logic r);
    @(negedge clk);
    btn = b;
    rst = r;
    @(posedge clk);
    model_edge(b, r);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic press_btn(input logic [3:0] b, input int hold, input int rel);
    repeat (hold) step(b, 1'b0);
    repeat (rel) step(4'b0000, 1'b0);
  endtask

  initial begin
    int entry_cyc;
    int guard;
    int hold;
    logic [3:0] rb;
    btn = '0;
    rst = 1'b1;

    step(4'b0000, 1'b1);
    chk("reset_state", 32'(state_o), 32'd0);
    repeat (50) step(4'b0000, 1'b0);
    chk("idle_no_en", 32'(en_cnt), 32'd0);
    chk("idle_state", 32'(state_o), 32'd0);

    entry_cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      step(4'b0010, 1'b0);
      if (i == 7) chk("start_lat_7", 32'(state_o), 32'd0);
      if (i == 8) begin
        chk("start_lat_8", 32'(state_o), 32'd1);
        entry_cyc = cyc;
        en_cnt = 0;
        first_en = -1;
      end
    end
    repeat (38) step(4'b0000, 1'b0);
    chk("five_ticks", 32'(en_cnt), 32'd5);
    chk("first_tick_gap", 32'(first_en - entry_cyc), 32'd10);

    press_btn(4'b0100, 8, 8);
    chk("stop_idle", 32'(state_o), 32'd0);

    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    repeat (12) step(4'b0000, 1'b0);
    chk("short_bounce", 32'(state_o), 32'd0);
    for (int i = 0; i < 40; i++) step((i % 2 == 0) ? 4'b0010 : 4'b0000, 1'b0);
    repeat (10) step(4'b0000, 1'b0);
    chk("toggle_bounce", 32'(state_o), 32'd0);

    press_btn(4'b0010, 8, 4);
    chk("run_again", 32'(state_o), 32'd1);
    ll_cnt = 0;
    en_cnt = 0;
    press_btn(4'b1000, 8, 15);
    chk("lap_state", 32'(state_o), 32'd2);
    chk("lap_disp", 32'(disp_lap), 32'd1);
    chk("lap_load_once", 32'(ll_cnt), 32'd1);
    chk("lap_en_continues", 32'(en_cnt >= 2), 32'd1);
    press_btn(4'b1000, 8, 4);
    chk("unlap_state", 32'(state_o), 32'd1);
    chk("unlap_disp", 32'(disp_lap), 32'd0);
    chk("unlap_no_load", 32'(ll_cnt), 32'd1);

    press_btn(4'b1000, 8, 4);
    clr_cnt = 0;
    press_btn(4'b0101, 8, 4);
    chk("clr_stop_state", 32'(state_o), 32'd0);
    chk("clr_stop_once", 32'(clr_cnt), 32'd1);
    chk("clr_stop_disp", 32'(disp_lap), 32'd0);

    en_cnt = 0;
    repeat (3) press_btn(4'b1000, 8, 6);
    chk("idle_steps", 32'(en_cnt), 32'd3);
    chk("idle_steps_state", 32'(state_o), 32'd0);

    press_btn(4'b0010, 8, 2);
    guard = 0;
    while (((k - m_entry) % TD) != 0 && guard < 20) begin
      step(4'b0000, 1'b0);
      guard++;
    end
    chk("tick_align", 32'(guard < 20), 32'd1);
    step(4'b0000, 1'b1);
    chk("rst_tick_en", 32'(cnt_en), 32'd0);
    chk("rst_tick_state", 32'(state_o), 32'd0);
    repeat (5) step(4'b0000, 1'b0);

    repeat (150) begin
      rb   = 4'($urandom_range(0, 15));
      hold = int'($urandom_range(1, 12));
      repeat (hold) step(rb, ($urandom_range(0, 199) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
